// File: rtl/detect_seq_pkg.sv
// rtl/detect_seq_pkg.sv - shared sizing and counter helpers for the programmable sequence detector
package detect_seq_pkg;

   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   // Saturates at 2^w-1; callers truncate the result back to their own width.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/detect_seq_next_state.sv
// rtl/detect_seq_next_state.sv - combinational KMP transition and border length of the loaded pattern
module detect_seq_next_state #(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = 4
) (
   input  logic [MAX_LEN-1:0] pat,
   input  logic [LEN_W-1:0]   len,
   input  logic [LEN_W-1:0]   st,
   input  logic               a,
   output logic [LEN_W-1:0]   nxt,
   output logic [LEN_W-1:0]   b_len
);

   // Pattern bit i in arrival order lives at pat[n-1-i].
   function automatic logic pbit(input logic [MAX_LEN-1:0] p, input int n, input int i);
      logic [MAX_LEN-1:0] sh;
      int                 idx;
      idx = n - 1 - i;
      sh  = '0;
      if (idx >= 0 && idx < MAX_LEN) begin
         sh = p >> idx;
      end
      return sh[0];
   endfunction

   always_comb begin
      logic match_n;
      logic match_b;
      int   n;
      int   s;
      int   m;
      nxt     = '0;
      b_len   = '0;
      match_n = 1'b0;
      match_b = 1'b0;
      m       = 0;
      n       = int'(len);
      s       = int'(st);
      for (int k = 1; k <= MAX_LEN; k++) begin
         match_n = (k <= s + 1);
         match_b = (k < n);
         for (int j = 0; j < MAX_LEN; j++) begin
            if (j < k) begin
               m = s + 1 - k + j;
               if (((m == s) ? a : pbit(pat, n, m)) != pbit(pat, n, j)) begin
                  match_n = 1'b0;
               end
               if (pbit(pat, n, n - k + j) != pbit(pat, n, j)) begin
                  match_b = 1'b0;
               end
            end
         end
         if (match_n) nxt = LEN_W'(k);
         if (match_b) b_len = LEN_W'(k);
      end
   end

endmodule

// File: rtl/detect_programmable_sequence.sv
// rtl/detect_programmable_sequence.sv - runtime-loaded serial pattern matcher with overlap mode and saturating match count
module detect_programmable_sequence
   import detect_seq_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   localparam int LEN_W  = len_w(MAX_LEN)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               a_valid,
   input  logic               a,
   input  logic               cnt_clr,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count
);

   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic [LEN_W-1:0]   st_q, st_d;
   logic               det_q, det_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [LEN_W-1:0]   nxt;
   logic [LEN_W-1:0]   b_len;
   logic               hit;

   detect_seq_next_state #(
      .MAX_LEN (MAX_LEN),
      .LEN_W   (LEN_W)
   ) u_next_state (
      .pat   (pat_q),
      .len   (len_q),
      .st    (st_q),
      .a     (a),
      .nxt   (nxt),
      .b_len (b_len)
   );

   always_comb begin
      pat_d = pat_q;
      len_d = len_q;
      ovl_d = ovl_q;
      st_d  = st_q;
      det_d = 1'b0;
      cnt_d = cnt_q;
      hit   = a_valid && (len_q != '0) && (nxt == len_q);
      if (cfg_load) begin
         pat_d = cfg_pattern;
         len_d = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;
         ovl_d = cfg_overlap;
         st_d  = '0;
         cnt_d = '0;
      end else begin
         if (cnt_clr) begin
            cnt_d = hit ? CNT_W'(1) : '0;
         end else if (hit) begin
            cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_W));
         end
         // Disabled (len==0) leaves st parked at 0.
         if (a_valid && (len_q != '0)) begin
            if (hit) begin
               det_d = 1'b1;
               st_d  = ovl_q ? b_len : '0;
            end else begin
               st_d  = nxt;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pat_q <= '0;
         len_q <= '0;
         ovl_q <= 1'b0;
         st_q  <= '0;
         det_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         pat_q <= pat_d;
         len_q <= len_d;
         ovl_q <= ovl_d;
         st_q  <= st_d;
         det_q <= det_d;
         cnt_q <= cnt_d;
      end
   end

   assign detected    = det_q;
   assign match_count = cnt_q;

endmodule

// File: tb/tb_detect_programmable_sequence.sv
// tb/tb_detect_programmable_sequence.sv - directed table-driven bench for detect_programmable_sequence
module tb_detect_programmable_sequence;

   logic       clk;
   logic       rst_n;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       a_valid;
   logic       a;
   logic       cnt_clr;
   logic       detected;
   logic [1:0] match_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       load;
      logic [7:0] pat;
      logic [3:0] len;
      logic       ovl;
      logic       v;
      logic       a;
      logic       clr;
      logic       edet;
      logic [1:0] ecnt;
   } vec_t;

   vec_t tbl[$];

   detect_programmable_sequence #(
      .MAX_LEN (8),
      .CNT_W   (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_load    (cfg_load),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .a_valid     (a_valid),
      .a           (a),
      .cnt_clr     (cnt_clr),
      .detected    (detected),
      .match_count (match_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void ld(input logic [7:0] p, input logic [3:0] l, input logic o, input logic ai);
      vec_t t;
      t.load = 1'b1; t.pat = p; t.len = l; t.ovl = o;
      t.v = 1'b1; t.a = ai; t.clr = 1'b0; t.edet = 1'b0; t.ecnt = 2'd0;
      tbl.push_back(t);
   endfunction

   function automatic void bt(input logic v, input logic ai, input logic clr,
                              input logic ed, input logic [1:0] ec);
      vec_t t;
      t.load = 1'b0; t.pat = 8'h00; t.len = 4'd0; t.ovl = 1'b0;
      t.v = v; t.a = ai; t.clr = clr; t.edet = ed; t.ecnt = ec;
      tbl.push_back(t);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      @(negedge clk);
      cfg_load    = t.load;
      cfg_pattern = t.pat;
      cfg_len     = t.len;
      cfg_overlap = t.ovl;
      a_valid     = t.v;
      a           = t.a;
      cnt_clr     = t.clr;
      @(posedge clk);
      #1;
      chk("detected", idx, {7'd0, detected}, {7'd0, t.edet});
      chk("match_count", idx, {6'd0, match_count}, {6'd0, t.ecnt});
   endtask

   task automatic run_table();
      foreach (tbl[i]) apply(tbl[i], i);
      tbl.delete();
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_load = 1'b0; cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0;
      a_valid = 1'b0; a = 1'b0; cnt_clr = 1'b0;
      #12;
      chk("reset_detected", -1, {7'd0, detected}, 8'd0);
      chk("reset_count", -1, {6'd0, match_count}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 110011, no overlap
      ld(8'h33, 4'd6, 1'b0, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1);
      // 110011 with overlap: border 2 gives a second hit
      ld(8'h33, 4'd6, 1'b1, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1);
      bt(1,0,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1); bt(1,1,0,1,2);
      // same stream without overlap
      ld(8'h33, 4'd6, 1'b0, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1);
      bt(1,0,0,0,1); bt(1,0,0,0,1); bt(1,1,0,0,1); bt(1,1,0,0,1);
      // 111 overlapping: back-to-back pulses, count saturates at 3
      ld(8'h07, 4'd3, 1'b1, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1); bt(1,1,0,1,2); bt(1,1,0,1,3); bt(1,1,0,1,3); bt(1,1,0,1,3);
      // valid gaps inside the pattern
      ld(8'h33, 4'd6, 1'b0, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(0,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0);
      bt(0,1,0,0,0); bt(0,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1); bt(0,0,0,0,1);
      // "10": saturation, then clear coincident with a match, then clear alone
      ld(8'h02, 4'd2, 1'b0, 1'b1);
      bt(1,1,0,0,0); bt(1,0,0,1,1); bt(1,1,0,0,1); bt(1,0,0,1,2); bt(1,1,0,0,2); bt(1,0,0,1,3);
      bt(1,1,0,0,3); bt(1,0,0,1,3); bt(1,1,0,0,3); bt(1,0,0,1,3); bt(1,1,0,0,3); bt(1,0,0,1,3);
      bt(1,1,0,0,3); bt(1,0,1,1,1); bt(0,0,1,0,0); bt(1,1,0,0,0); bt(1,0,0,1,1);
      // cfg_len above MAX_LEN clamps to 8
      ld(8'hFF, 4'd15, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) bt(1,1,0,0,0);
      bt(1,1,0,1,1); bt(1,1,0,0,1);
      // len 0 disables matching
      ld(8'hFF, 4'd0, 1'b1, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0);
      // reload mid-pattern discards the partial match
      ld(8'h33, 4'd6, 1'b0, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,0,0); bt(1,0,0,0,0);
      ld(8'h06, 4'd4, 1'b0, 1'b0);
      bt(1,0,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,0,0,1,1);
      run_table();

      // async reset right after a match clears outputs without a clock edge
      ld(8'h07, 4'd3, 1'b1, 1'b1);
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,1,1);
      run_table();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_detected", -2, {7'd0, detected}, 8'd0);
      chk("async_rst_count", -2, {6'd0, match_count}, 8'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0); bt(1,1,0,0,0);
      run_table();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
